// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store unit.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    memop_nop,
    l_byte,
    l_hword,
    l_word,
    l_ubyte,
    l_uhword,
    s_byte,
    s_hword,
    s_word
  } rv32_memop;

  typedef logic [1:0] mau_state_t;

  localparam mau_state_t StIdle  = 2'd0;
  localparam mau_state_t StBeat0 = 2'd1;
  localparam mau_state_t StBeat1 = 2'd2;
  localparam mau_state_t StResp  = 2'd3;

  function automatic logic memop_is_load(input rv32_memop op);
    return (op == l_byte) || (op == l_hword) || (op == l_word) ||
           (op == l_ubyte) || (op == l_uhword);
  endfunction

  function automatic logic memop_is_store(input rv32_memop op);
    return (op == s_byte) || (op == s_hword) || (op == s_word);
  endfunction

  // Access width in bytes; 0 for nop.
  function automatic logic [2:0] memop_size(input rv32_memop op);
    logic [2:0] size;
    case (op)
      l_byte, l_ubyte, s_byte:   size = 3'd1;
      l_hword, l_uhword, s_hword: size = 3'd2;
      l_word, s_word:            size = 3'd4;
      default:                   size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Sign/zero extension of assembled little-endian load data.
module mem_access_unit_load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] data_i,
  input  rv32_memop   memop_i,
  output logic [31:0] rdata_o
);

  // Pick the extension rule from the load type
  always_comb begin
    rdata_o = data_i;
    case (memop_i)
      l_byte:   rdata_o = {{24{data_i[7]}}, data_i[7:0]};
      l_ubyte:  rdata_o = {24'h000000, data_i[7:0]};
      l_hword:  rdata_o = {{16{data_i[15]}}, data_i[15:0]};
      l_uhword: rdata_o = {16'h0000, data_i[15:0]};
      default:  rdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one request at a time, optional two-beat split for
// misaligned accesses, per-beat timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit          ALLOW_MISALIGNED = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES   = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  rv32_memop   i_memop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_fault,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mau_state_t      state_q;
  rv32_memop       op_q;
  logic [1:0]      off_q;
  logic [3:0]      mask_hi_q;
  logic [31:0]     wdata_q;
  logic [31:0]     asm_q;
  logic            fault_q;
  logic            misal_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [31:0]     bus_addr_q;
  logic [3:0]      bus_be_q;
  logic [31:0]     bus_wdata_q;

  logic            accept;
  logic [2:0]      req_size;
  logic [7:0]      req_mask;
  logic            req_misal;
  logic            req_reject;
  logic            beat_ack;
  logic            beat_expire;
  logic [31:0]     ack_bytes;
  logic [5:0]      hi_shift;
  logic [31:0]     ext_data;

  assign accept = i_valid && o_ready;

  // Decode the incoming request: byte mask across two words and alignment
  always_comb begin
    req_size   = memop_size(i_memop);
    req_misal  = ((req_size == 3'd2) && i_addr[0]) ||
                 ((req_size == 3'd4) && (i_addr[1:0] != 2'b00));
    req_mask   = 8'(((8'd1 << req_size) - 8'd1) << i_addr[1:0]);
    req_reject = req_misal && !ALLOW_MISALIGNED;
  end

  // Beat completion and timeout expiry; an ack on the expiry edge wins
  always_comb begin
    beat_ack    = bus_req_q && i_bus_ack;
    beat_expire = (TIMEOUT_CYCLES != 0) && bus_req_q && !i_bus_ack &&
                  (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  end

  // Keep only the bytes this beat asked for; shift amount for the upper-word beat
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ack_bytes[8*i +: 8] = bus_be_q[i] ? i_bus_rdata[8*i +: 8] : 8'h00;
    end
    hi_shift = 6'd32 - {1'b0, off_q, 3'b000};
  end

  // Main FSM, beat generation, load assembly and timeout counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      op_q        <= memop_nop;
      off_q       <= 2'b00;
      mask_hi_q   <= 4'h0;
      wdata_q     <= 32'h0;
      asm_q       <= 32'h0;
      fault_q     <= 1'b0;
      misal_q     <= 1'b0;
      to_cnt_q    <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q      <= i_memop;
            off_q     <= i_addr[1:0];
            mask_hi_q <= req_mask[7:4];
            wdata_q   <= i_wdata;
            asm_q     <= 32'h0;
            fault_q   <= 1'b0;
            misal_q   <= req_reject;
            if ((i_memop == memop_nop) || req_reject) begin
              state_q <= StResp;
            end else begin
              state_q     <= StBeat0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= memop_is_store(i_memop);
              bus_addr_q  <= {i_addr[31:2], 2'b00};
              bus_be_q    <= req_mask[3:0];
              bus_wdata_q <= i_wdata << {i_addr[1:0], 3'b000};
              to_cnt_q    <= '0;
            end
          end
        end
        StBeat0, StBeat1: begin
          if (bus_req_q) begin
            if (beat_ack) begin
              bus_req_q <= 1'b0;
              if (i_bus_err) begin
                fault_q <= 1'b1;
                state_q <= StResp;
              end else begin
                if (state_q == StBeat0) begin
                  asm_q <= ack_bytes >> {off_q, 3'b000};
                end else begin
                  asm_q <= asm_q | (ack_bytes << hi_shift);
                end
                if ((state_q == StBeat0) && (mask_hi_q != 4'h0)) begin
                  state_q <= StBeat1;
                end else begin
                  state_q <= StResp;
                end
              end
            end else if (beat_expire) begin
              bus_req_q <= 1'b0;
              fault_q   <= 1'b1;
              state_q   <= StResp;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end else begin
            // Only reached in StBeat1: req was low for one cycle, launch the upper beat
            bus_req_q   <= 1'b1;
            bus_addr_q  <= bus_addr_q + 32'd4;
            bus_be_q    <= mask_hi_q;
            bus_wdata_q <= wdata_q >> hi_shift;
            to_cnt_q    <= '0;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  mem_access_unit_load_extender u_load_extender (
    .data_i  (asm_q),
    .memop_i (op_q),
    .rdata_o (ext_data)
  );

  // Response flags are qualified by the one-cycle response state
  always_comb begin
    o_ready      = (state_q == StIdle) && !i_rst;
    o_done       = (state_q == StResp);
    o_misaligned = o_done && misal_q;
    o_fault      = o_done && fault_q;
    o_rdata      = (o_done && memop_is_load(op_q) && !fault_q && !misal_q) ? ext_data : 32'h0;
    o_bus_req    = bus_req_q;
    o_bus_we     = bus_we_q;
    o_bus_addr   = bus_addr_q;
    o_bus_be     = bus_be_q;
    o_bus_wdata  = bus_wdata_q;
  end

endmodule
